barcode_price_decoder: RTL and testbench

- Upstream stage of the change-giving machine: samples the scanner's serial bar signal, decodes one price frame, and drives the 5-bit PG input the vending core consumes.
- Presents PG as a level held for a fixed number of cycles, then returns it to 0, which is the pulse shape the core expects.
- Rejects malformed, parity-failing or out-of-range frames with an error pulse. A rejected frame never drives PG.

---
 rtl/barcode_pkg.sv | 36 +++
 rtl/bar_run_counter.sv | 46 ++++
 rtl/barcode_price_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_barcode_price_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/barcode_pkg.sv
// Shared definitions for the barcode price decoder.
//   - scanner FSM state encodings (3 bits, exported on scanState)
//   - frame geometry: PRICE_W data bits plus one parity bit
//   - default bar-width / timing parameters
//   - even-parity and small integer helpers
package barcode_pkg;

  localparam int PRICE_W    = 5;
  localparam int FRAME_BITS = 6;

  localparam int NARROW_MAX_DEF  = 3;
  localparam int WIDE_MAX_DEF    = 6;
  localparam int START_MAX_DEF   = 10;
  localparam int TIMEOUT_DEF     = 12;
  localparam int HOLD_CYCLES_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_GAP   = 3'd2,
    S_BAR   = 3'd3,
    S_CHECK = 3'd4,
    S_HOLD  = 3'd5,
    S_FLUSH = 3'd6
  } scan_state_e;

  // True when the frame carries an even number of ones.
  function automatic logic even_parity(input logic [FRAME_BITS-1:0] frame);
    return ~(^frame);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bar_run_counter.sv
// Run-length counter for the scanner bar signal.
//   clock, reset : system clock, synchronous active-high reset
//   bar_i        : current scanner sample (1 = black)
//   count_o      : length of the run held in level_o, saturating at SAT
//   level_o      : level of the run being counted (previous sample)
//   changed_o    : bar_i differs from level_o; the run in count_o ends at
//                  this edge and the counter reloads 1 for the new level
module bar_run_counter #(
  parameter int SAT = 13,
  parameter int CW  = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          bar_i,
  output logic [CW-1:0] count_o,
  output logic          level_o,
  output logic          changed_o
);

  logic          level_q;
  logic [CW-1:0] count_q, count_d;

  assign changed_o = bar_i != level_q;
  assign count_o   = count_q;
  assign level_o   = level_q;

  always_comb begin
    count_d = count_q;
    if (changed_o) begin
      count_d = CW'(1);
    end else if (count_q != CW'(SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      level_q <= bar_i;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/barcode_price_decoder.sv
// Decodes one serial barcode price frame (start bar, 5 data bars MSB
// first, 1 parity bar) and presents the price as a held level.
//   clock, reset : system clock, synchronous active-high reset
//   bar          : synchronised scanner sample, 1 = black
//   PG           : decoded price, nonzero only while valid is high
//   valid        : high for HOLD_CYCLES cycles after an accepted frame
//   err          : one-cycle pulse when a frame is rejected
//   scanState    : current FSM state (debug)
//
// state | meaning
// IDLE  | waiting for the first black sample
// START | measuring the start bar
// GAP   | white separator between bars, bounded by TIMEOUT
// BAR   | measuring a data/parity bar
// CHECK | one cycle: parity and price range check
// HOLD  | PG/valid driven, bar ignored
// FLUSH | waiting for TIMEOUT+1 consecutive whites before rearming
module barcode_price_decoder
  import barcode_pkg::*;
#(
  parameter int NARROW_MAX  = NARROW_MAX_DEF,
  parameter int WIDE_MAX    = WIDE_MAX_DEF,
  parameter int START_MAX   = START_MAX_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               bar,
  output logic [PRICE_W-1:0] PG,
  output logic               valid,
  output logic               err,
  output logic [2:0]         scanState
);

  // The run counter also times white gaps, so it must be able to reach
  // TIMEOUT as well as classify anything beyond START_MAX.
  localparam int RUN_SAT = max2(START_MAX + 1, TIMEOUT + 1);
  localparam int RW      = $clog2(RUN_SAT + 1);
  localparam int AW      = $clog2(max2(HOLD_CYCLES, TIMEOUT) + 1);

  logic [RW-1:0] run_cnt;
  logic          run_level;
  logic          run_changed;

  bar_run_counter #(
    .SAT (RUN_SAT),
    .CW  (RW)
  ) u_run (
    .clock     (clock),
    .reset     (reset),
    .bar_i     (bar),
    .count_o   (run_cnt),
    .level_o   (run_level),
    .changed_o (run_changed)
  );

  scan_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [2:0]              bitcnt_q, bitcnt_d;
  logic [AW-1:0]           aux_q, aux_d;     // hold counter in HOLD, white counter in FLUSH
  logic [PRICE_W-1:0]      pg_q, pg_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    black_end;
  logic                    data_bit;
  logic                    start_ok;
  logic                    frame_ok;
  logic [PRICE_W-1:0]      frame_data;

  // A black run finishes at this edge; run_cnt still holds its length.
  assign black_end  = run_changed & run_level;
  assign data_bit   = run_cnt > RW'(NARROW_MAX);
  assign start_ok   = (run_cnt >= RW'(WIDE_MAX + 1)) && (run_cnt <= RW'(START_MAX));
  assign frame_data = sr_q[FRAME_BITS-1:1];
  // Only even prices 2..30 are legal.
  assign frame_ok   = even_parity(sr_q) & ~frame_data[0] & (|frame_data);

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    aux_d    = aux_q;
    pg_d     = pg_q;
    valid_d  = valid_q;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bar) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (black_end) begin
          if (start_ok) begin
            state_d  = S_GAP;
            bitcnt_d = '0;
            sr_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (run_changed) begin
          state_d = S_BAR;
        end else if (run_cnt == RW'(TIMEOUT)) begin
          // this white sample would be number TIMEOUT+1
          state_d = S_FLUSH;
          err_d   = 1'b1;
          aux_d   = '0;
        end
      end

      S_BAR: begin
        if (black_end) begin
          sr_d     = {sr_q[FRAME_BITS-2:0], data_bit};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(FRAME_BITS - 1)) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_GAP;
          end
        end else if (run_cnt == RW'(WIDE_MAX)) begin
          // this black sample would be number WIDE_MAX+1
          state_d = S_FLUSH;
          err_d   = 1'b1;
          aux_d   = '0;
        end
      end

      S_CHECK: begin
        if (frame_ok) begin
          state_d = S_HOLD;
          pg_d    = frame_data;
          valid_d = 1'b1;
          aux_d   = AW'(1);
        end else begin
          state_d = S_FLUSH;
          err_d   = 1'b1;
          aux_d   = '0;
        end
      end

      S_HOLD: begin
        if (aux_q == AW'(HOLD_CYCLES)) begin
          state_d = S_FLUSH;
          pg_d    = '0;
          valid_d = 1'b0;
          aux_d   = '0;
        end else begin
          aux_d = aux_q + AW'(1);
        end
      end

      S_FLUSH: begin
        if (bar) begin
          aux_d = '0;
        end else if (aux_q == AW'(TIMEOUT)) begin
          state_d = S_IDLE;
          aux_d   = '0;
        end else begin
          aux_d = aux_q + AW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        pg_d    = '0;
        valid_d = 1'b0;
        aux_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      bitcnt_q <= '0;
      aux_q    <= '0;
      pg_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      aux_q    <= aux_d;
      pg_q     <= pg_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign PG        = pg_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign scanState = state_q;

endmodule

// File: tb/tb_barcode_price_decoder.sv
module tb_barcode_price_decoder;

  localparam int HOLD = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       bar;
  logic [4:0] PG;
  logic       valid;
  logic       err;
  logic [2:0] scanState;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit is_err;
    int price;
  } exp_t;

  exp_t sb[$];

  bit         mon_en = 1'b0;
  logic       valid_p = 1'b0;
  logic       err_p = 1'b0;
  int         hold_len = 0;
  logic [4:0] hold_pg = '0;

  barcode_price_decoder dut (
    .clock     (clock),
    .reset     (reset),
    .bar       (bar),
    .PG        (PG),
    .valid     (valid),
    .err       (err),
    .scanState (scanState)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Each call produces exactly n rising-edge samples of level b.
  task automatic drive(input logic b, input int n);
    repeat (n) begin
      @(negedge clock);
      bar = b;
    end
  endtask

  function automatic logic [5:0] mk(input logic [4:0] p);
    return {p, ^p};
  endfunction

  // Start bar, then nbars bars (narrow 2 / wide 5) each preceded by gap whites.
  // Bar number sp_idx gets width sp_w instead.
  task automatic send_frame(input int slen, input logic [5:0] code, input int gap,
                            input int nbars, input int sp_idx, input int sp_w);
    drive(1'b1, slen);
    for (int i = 0; i < nbars; i++) begin
      drive(1'b0, gap);
      drive(1'b1, (i == sp_idx) ? sp_w : (code[5-i] ? 5 : 2));
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      drive(1'b0, 1);
      if (sb.size() == 0 && scanState == 3'd0 && !valid) done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  // Scoreboard / protocol monitor, sampling on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (valid && !valid_p) begin
        chk("valid_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("valid_kind", e.is_err, 0);
          chk("price", PG, e.price);
        end
        hold_len = 1;
        hold_pg  = PG;
      end else if (valid) begin
        hold_len++;
        chk("pg_stable", PG, hold_pg);
      end else begin
        if (valid_p) chk("hold_len", hold_len, HOLD);
        chk("pg_idle_zero", PG, 0);
      end
      if (err) begin
        chk("err_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("err_kind", e.is_err, 1);
        end
        chk("err_with_valid", valid, 0);
        chk("err_one_cycle", err_p, 0);
      end
    end
    valid_p = valid;
    err_p   = err;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int prices[3] = '{10, 2, 30};

    bar   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_pg", PG, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_state", scanState, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    drive(1'b0, 3);

    // price 28 with exact timing
    sb.push_back('{1'b0, 28});
    send_frame(8, mk(5'd28), 2, 6, -1, 0);
    drive(1'b0, 1);
    drive(1'b0, 1);
    chk("t1_check_state", scanState, 4);
    chk("t1_no_valid_yet", valid, 0);
    drive(1'b0, 1);
    chk("t1_valid", valid, 1);
    chk("t1_pg", PG, 28);
    chk("t1_hold_state", scanState, 5);
    drive(1'b0, 5);
    chk("t1_still_valid", valid, 1);
    drive(1'b0, 1);
    chk("t1_valid_off", valid, 0);
    chk("t1_pg_off", PG, 0);
    chk("t1_flush", scanState, 6);
    drive(1'b0, 12);
    chk("t1_flush_wait", scanState, 6);
    drive(1'b0, 1);
    chk("t1_idle", scanState, 0);

    // further legal prices
    foreach (prices[i]) begin
      sb.push_back('{1'b0, prices[i]});
      send_frame(8, mk(5'(prices[i])), 2, 6, -1, 0);
      wait_idle("t2_drain");
    end

    // rejected frames
    sb.push_back('{1'b1, 0});
    send_frame(8, mk(5'd28) ^ 6'b000001, 2, 6, -1, 0);
    wait_idle("t3_bad_parity");
    sb.push_back('{1'b1, 0});
    send_frame(8, mk(5'd7), 2, 6, -1, 0);
    wait_idle("t3_odd_price");
    sb.push_back('{1'b1, 0});
    send_frame(8, mk(5'd0), 2, 6, -1, 0);
    wait_idle("t3_zero_price");

    // gap of TIMEOUT is legal
    sb.push_back('{1'b0, 10});
    send_frame(8, mk(5'd10), 12, 6, -1, 0);
    wait_idle("t4_gap12");

    // gap of TIMEOUT+1 after the 3rd data bar
    sb.push_back('{1'b1, 0});
    send_frame(8, mk(5'd28), 2, 3, -1, 0);
    drive(1'b0, 13);
    drive(1'b0, 1);
    chk("t4_gap13_err", err, 1);
    chk("t4_gap13_flush", scanState, 6);
    wait_idle("t4_gap13_drain");

    // data bar of WIDE_MAX is a 1
    sb.push_back('{1'b0, 16});
    send_frame(8, mk(5'd16), 2, 6, 0, 6);
    wait_idle("t4_bar6");

    // data bar of WIDE_MAX+1 is an error
    sb.push_back('{1'b1, 0});
    send_frame(8, mk(5'd16), 2, 1, 0, 7);
    drive(1'b0, 1);
    chk("t4_bar7_err", err, 1);
    chk("t4_bar7_flush", scanState, 6);
    wait_idle("t4_bar7_drain");

    // start bars outside 7..10 are silent noise
    send_frame(6, 6'd0, 2, 0, -1, 0);
    drive(1'b0, 2);
    chk("t4_start6_idle", scanState, 0);
    chk("t4_start6_err", err, 0);
    send_frame(11, 6'd0, 2, 0, -1, 0);
    drive(1'b0, 2);
    chk("t4_start11_idle", scanState, 0);
    chk("t4_start11_err", err, 0);
    drive(1'b0, 2);

    // start bar of START_MAX and WIDE_MAX+1 are accepted
    sb.push_back('{1'b0, 2});
    send_frame(10, mk(5'd2), 2, 6, -1, 0);
    wait_idle("t4_start10");
    sb.push_back('{1'b0, 30});
    send_frame(7, mk(5'd30), 2, 6, -1, 0);
    wait_idle("t4_start7");

    // reset during the 4th data bar
    send_frame(8, mk(5'd16), 2, 3, -1, 0);
    drive(1'b0, 2);
    drive(1'b1, 2);
    @(negedge clock);
    reset = 1'b1;
    bar   = 1'b0;
    @(negedge clock);
    chk("t5_rst_state", scanState, 0);
    chk("t5_rst_pg", PG, 0);
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_err", err, 0);
    reset = 1'b0;
    drive(1'b0, 3);
    sb.push_back('{1'b0, 16});
    send_frame(8, mk(5'd16), 2, 6, -1, 0);
    wait_idle("t5_after_reset");

    // new frame during HOLD is ignored
    sb.push_back('{1'b0, 28});
    send_frame(8, mk(5'd28), 2, 6, -1, 0);
    drive(1'b0, 3);
    chk("t6_valid", valid, 1);
    send_frame(8, mk(5'd10), 2, 6, -1, 0);
    chk("t6_flush_busy", scanState, 6);
    wait_idle("t6_drain");

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
